// File: rtl/coin_key_in_pio_if.sv
// coin_key_in_pio_if: Avalon-MM s1 slave bus for the coin/key input PIO
//   address[1:0], chipselect, write_n, writedata[WIDTH-1:0] : master -> slave
//   readdata[WIDTH-1:0]                                     : slave -> master, zero wait states
interface coin_key_in_pio_if #(parameter int WIDTH = 4);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;
  modport slave (input address, chipselect, write_n, writedata, output readdata);
  modport master(output address, chipselect, write_n, writedata, input readdata);
endinterface

// File: rtl/coin_key_in_pio.sv
// coin_key_in_pio: synchronized, debounced coin/key input PIO with edge capture and maskable irq
//   clk, reset_n (async, active-low) | s1: Avalon-MM slave (coin_key_in_pio_if.slave)
//   in_port[WIDTH-1:0]: raw asynchronous lines | irq: registered level interrupt
//   Registers: 0 DATA (debounced levels, RO), 1 reads 0, 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (W1C)
//   COIN_KEY_DEBOUNCE_EN defined: per-bit debounce counters; undefined: stable follows sync2 each edge
module coin_key_in_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  coin_key_in_pio_if.slave       s1,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);
  if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cfg
    $error("coin_key_in_pio: DEBOUNCE_CYCLES must be >= 2 and < 2**CNT_W");
  end
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] rise;
  logic             irq_q, irq_d;
  logic             wr;
`ifdef COIN_KEY_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
`else
  always_comb stable_d = sync2_q;
`endif
  // rise comes from the update term so edge_capture sets on the same edge stable rises
  always_comb begin
    wr       = s1.chipselect && !s1.write_n;
    rise     = stable_d & ~stable_q;
    mask_d   = (wr && s1.address == 2'd2) ? s1.writedata : mask_q;
    edge_d   = (edge_q & ~((wr && s1.address == 2'd3) ? s1.writedata : '0)) | rise;
    irq_d    = |(edge_q & mask_q);
  end
  assign s1.readdata = !s1.chipselect      ? '0       :
                       s1.address == 2'd0  ? stable_q :
                       s1.address == 2'd2  ? mask_q   :
                       s1.address == 2'd3  ? edge_q   : '0;
  assign irq = irq_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= in_port;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      irq_q    <= irq_d;
    end
endmodule

// File: tb/tb_coin_key_in_pio.sv
// tb_coin_key_in_pio: directed bench with a history-based reference model of coin_key_in_pio
module tb_coin_key_in_pio;
  localparam int W = 4;
  localparam int D = 4;
`ifdef COIN_KEY_DEBOUNCE_EN
  localparam int LAT = D + 1;
`else
  localparam int LAT = 2;
`endif
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic         irq;
  int           errs = 0;
  int           checks = 0;

  coin_key_in_pio_if #(.WIDTH(W)) bus();
  coin_key_in_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .s1(bus.slave), .in_port(in_port), .irq(irq));

  always #5 clk = ~clk;

  // h[k] holds in_port as sampled k+1 edges ago; h[1] is what the sync chain presents now
  logic [W-1:0] h [0:D+1];
  logic [W-1:0] m_stab, m_ec, m_mask;
  logic         m_irq;

  // a level is accepted once the delayed input has disagreed with it for D edges in a row
  function automatic logic [W-1:0] next_stab();
    logic [W-1:0] ns = m_stab;
`ifdef COIN_KEY_DEBOUNCE_EN
    for (int i = 0; i < W; i++) begin
      bit differ = 1'b1;
      for (int j = 1; j <= D; j++) if (h[j][i] == m_stab[i]) differ = 1'b0;
      if (differ) ns[i] = h[1][i];
    end
`else
    ns = h[1];
`endif
    return ns;
  endfunction

  function automatic logic [W-1:0] wr_data(input logic [1:0] a);
    return (bus.chipselect && !bus.write_n && bus.address == a) ? bus.writedata : '0;
  endfunction

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int k = 0; k <= D + 1; k++) h[k] <= '0;
      m_stab <= '0; m_ec <= '0; m_mask <= '0; m_irq <= 1'b0;
    end else begin
      for (int k = 1; k <= D + 1; k++) h[k] <= h[k-1];
      h[0]   <= in_port;
      m_stab <= next_stab();
      m_ec   <= (m_ec & ~wr_data(2'd3)) | (next_stab() & ~m_stab);
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask <= bus.writedata;
      m_irq  <= |(m_ec & m_mask);
    end

  function automatic logic [W-1:0] exp_rd();
    if (!bus.chipselect) return '0;
    case (bus.address)
      2'd0: return m_stab;
      2'd2: return m_mask;
      2'd3: return m_ec;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_irq", {3'b0, irq}, {3'b0, m_irq});
    chk("model_rd", bus.readdata, exp_rd());
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [1:0] a, input logic [W-1:0] exp);
    bus.address = a;
    #1 chk(name, bus.readdata, exp);
    bus.address = 2'd0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    bus.address = a; bus.writedata = d; bus.write_n = 1'b0;
    tick();
    bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = '0;
    in_port = 4'hF;
    tick(3);
    lit("rst_data", 2'd0, 4'h0);
    chk("rst_irq", {3'b0, irq}, 4'h0);
    reset_n = 1'b1;
    for (int e = 0; e < LAT; e++) begin
      tick();
      lit("post_rst_data", 2'd0, 4'h0);
      lit("post_rst_mask", 2'd2, 4'h0);
      lit("post_rst_edge", 2'd3, 4'h0);
      chk("post_rst_irq", {3'b0, irq}, 4'h0);
    end
    tick();
    lit("held_data", 2'd0, 4'hF);
    lit("held_edge", 2'd3, 4'hF);
    tick();
    lit("held_data2", 2'd0, 4'hF);
    lit("held_edge2", 2'd3, 4'hF);
    chk("held_irq_masked", {3'b0, irq}, 4'h0);
    wr(2'd3, 4'hF);
    lit("edge_cleared", 2'd3, 4'h0);
    wr(2'd2, 4'hA);
    lit("mask_rb", 2'd2, 4'hA);
    in_port = 4'h0;
    tick(LAT + 3);
    wr(2'd2, 4'h1);
    in_port = 4'h1;
    for (int e = 0; e < LAT; e++) begin
      tick();
      lit("press_early", 2'd0, 4'h0);
      chk("press_irq_early", {3'b0, irq}, 4'h0);
    end
    tick();
    lit("press_data", 2'd0, 4'h1);
    lit("press_edge", 2'd3, 4'h1);
    chk("press_irq_same", {3'b0, irq}, 4'h0);
    tick();
    chk("press_irq", {3'b0, irq}, 4'h1);
    wr(2'd3, 4'h1);
    chk("clr_irq_lag", {3'b0, irq}, 4'h1);
    tick();
    chk("clr_irq", {3'b0, irq}, 4'h0);
    in_port = 4'h0;
    tick(LAT + 3);
`ifdef COIN_KEY_DEBOUNCE_EN
    wr(2'd2, 4'hF);
    in_port = 4'h2;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (c == 2 || c == 6) in_port = 4'h0;
      if (c == 3) in_port = 4'h2;
      lit("glitch_data", 2'd0, 4'h0);
      lit("glitch_edge", 2'd3, 4'h0);
      chk("glitch_irq", {3'b0, irq}, 4'h0);
    end
`endif
    wr(2'd2, 4'h4);
    in_port = 4'h5;
    tick(LAT + 2);
    lit("w1c_pre", 2'd3, 4'h5);
    chk("w1c_pre_irq", {3'b0, irq}, 4'h1);
    wr(2'd3, 4'h1);
    lit("w1c_one", 2'd3, 4'h4);
    tick();
    chk("w1c_irq_kept", {3'b0, irq}, 4'h1);
    wr(2'd3, 4'h4);
    lit("w1c_all", 2'd3, 4'h0);
    chk("w1c_irq_lag", {3'b0, irq}, 4'h1);
    tick();
    chk("w1c_irq_drop", {3'b0, irq}, 4'h0);
    in_port = 4'h7;
    tick(LAT);
    wr(2'd3, 4'h2);
    lit("collide_set_wins", 2'd3, 4'h2);
    lit("collide_data", 2'd0, 4'h7);
    wr(2'd3, 4'h2);
    lit("collide_then_clr", 2'd3, 4'h0);
    in_port = 4'h8;
    for (int e = 0; e < LAT; e++) begin
      tick();
      lit("step8_early", 2'd0, 4'h7);
    end
    tick();
    lit("step8_data", 2'd0, 4'h8);
    lit("step8_edge", 2'd3, 4'h8);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/coin_key_in_pio.md
Name: coin_key_in_pio

Overview:
- Avalon-MM slave input port for the vending controller. It samples asynchronous coin-slot and push-button lines and synchronizes and debounces them.
- Presents the debounced levels to the Nios CPU, latches rising edges in an edge-capture register, and raises a maskable interrupt.
- Read-side counterpart of the single-bit output PIOs such as the enough-money lamp driver. Shares the same s1 register-map style: 2-bit address, zero-wait reads, chipselect/write_n qualification.

Parameters:
- WIDTH, 4: number of input lines (coin 1, coin 5, coin 10, cancel key).
- DEBOUNCE_CYCLES, 50000: clk cycles an input must hold a new level before it is accepted (1 ms at 50 MHz). Must be at least 2.
- CNT_W, 16: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- address, input, 2: s1 register select.
- chipselect, input, 1: s1 select.
- write_n, input, 1: active-low write strobe.
- writedata, input, WIDTH: write data.
- readdata, output, WIDTH: read data, combinational from address, zero wait states.
- in_port, input, WIDTH: raw asynchronous external lines, active-high.
- irq, output, 1: level interrupt to CPU.

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk. On reset the following clear to 0:
  - sync1 and sync2
  - stable
  - all debounce counters
  - irq_mask
  - edge_capture
  - irq, which is therefore 0 during and after reset
- Reset mid-debounce discards the count.
- Synchronizer: per bit, two flops. in_port -> sync1 -> sync2. No logic between the two flops.
- Debounce, per bit i, evaluated every clk edge:
  - If sync2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles returns sync2 to stable, clears cnt, and never changes stable.
- Latency: an in_port step before edge 0 appears in stable after edge DEBOUNCE_CYCLES+1, i.e. D+2 edges in total.
- Edge detect: rise[i] = 1 in the cycle where stable[i] goes 0 -> 1. It is computed from the debounce update term, so edge_capture[i] sets on the same edge stable[i] rises. Falling edges are ignored.
- A line held high through reset release produces one rising edge once debounced, because stable resets to 0.
- Register map, read when chipselect is asserted (readdata is undefined-but-0 otherwise):
  - addr 0, DATA: reads stable. Writes ignored.
  - addr 1: reads 0. Writes ignored.
  - addr 2, IRQ_MASK: read/write. Write when chipselect && !write_n && address==2.
  - addr 3, EDGE_CAPTURE: reads edge_capture. A write clears each bit where writedata[i]==1 (write-1-to-clear).
- Simultaneous rise[i] and a clear of bit i on the same edge: the set wins and bit i stays 1.
- irq is registered: irq <= |(edge_capture & irq_mask), one cycle after either operand changes.
- Unmasking a bit that is already captured asserts irq on the next edge.

Optional Feature:
- Macro COIN_KEY_DEBOUNCE_EN.
- Defined: debounce counters are present as specified above.
- Undefined:
  - No counters are instantiated.
  - stable <= sync2 every edge, giving a latency of 3 edges from in_port to stable.
  - Edge detect is unchanged, using stable vs. its previous value.
  - DEBOUNCE_CYCLES and CNT_W are ignored.

Test Plan (bench uses WIDTH=4, DEBOUNCE_CYCLES=4, COIN_KEY_DEBOUNCE_EN defined):
1. Reset state: assert reset_n=0 with in_port=4'hF, then release. Required: irq=0 and reads of addr 0/2/3 all return 0 for the first 5 edges. After edge 6, addr0 reads 4'hF and addr3 reads 4'hF.
2. Clean press: drive in_port[0] 0 -> 1 before edge 0 and hold it. Required:
   - addr0 reads 4'h1 after edge 5, not before.
   - addr3 bit0 reads 1.
   - With irq_mask=4'h1 written beforehand, irq=1 after edge 6.
3. Glitch rejection: pulse in_port[1] high for 3 cycles. Required: addr0 and addr3 stay 4'h0, irq stays 0, and cnt returns to 0.
4. Write-1-to-clear: edge_capture=4'h5, write 4'h1 to addr3. Required: addr3 reads 4'h4. With mask 4'h4, irq stays 1. Write 4'h4 to addr3: irq=0 one edge later.
5. Set/clear collision: time a write of 4'h2 to addr3 on the same edge stable[1] rises. Required: edge_capture[1] reads 1 afterwards.
6. Without COIN_KEY_DEBOUNCE_EN: step in_port to 4'h8 before edge 0. Required: addr0 reads 4'h8 after edge 2, and addr3 bit3 = 1.
